// File: rtl/vga_scanout.sv
// VGA scan-out stage: rebuilds the active window from hsync/vsync edges, streams framebuffer reads
// and emits RGB with syncs delayed so both paths stay cycle-aligned.
module vga_scanout #(
  parameter int H_ACTIVE = 320,
  parameter int H_BACK   = 40,
  parameter int V_ACTIVE = 240,
  parameter int V_BACK   = 25,
  parameter int V_TOTAL  = 269,
  parameter int RD_LAT   = 2,
  parameter int PIX_W    = 12,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [PIX_W-1:0]  fb_rdata,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [PIX_W-1:0]  vga_rgb,
  output logic              vga_de,
  output logic              frame_start,
  output logic              sync_err
);

  localparam int L    = RD_LAT + 2;
  localparam int HC_W = $clog2(H_BACK + H_ACTIVE + 1);
  localparam int LC_W = $clog2(V_TOTAL + V_BACK + V_ACTIVE + 2);

  localparam logic [HC_W-1:0] H_START = HC_W'(H_BACK);
  localparam logic [HC_W-1:0] H_END   = HC_W'(H_BACK + H_ACTIVE);
  localparam logic [LC_W-1:0] V_START = LC_W'(V_BACK);
  localparam logic [LC_W-1:0] V_END   = LC_W'(V_BACK + V_ACTIVE);
  localparam logic [LC_W-1:0] V_TOT   = LC_W'(V_TOTAL);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } tap_t;

  localparam tap_t TAP_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};

  state_t              state_q, state_d;
  logic                hs_prev_q, hs_prev_d;
  logic                vs_prev_q, vs_prev_d;
  logic [HC_W-1:0]     hcnt_q, hcnt_d;
  logic [LC_W-1:0]     line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic                fb_rd_en_q, fb_rd_en_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic                sync_err_q, sync_err_d;
  logic [PIX_W-1:0]    vga_rgb_q, vga_rgb_d;
  tap_t                pipe_q [L];
  tap_t                pipe_d [L];

  logic                hs_rise, vs_rise, locked, active;
  logic [HC_W-1:0]     hcnt_eff;
  logic [LC_W-1:0]     line_eff;
  logic [ADDR_W-1:0]   addr_eff;

  // The *_eff values are the counters as seen in the current cycle, after this cycle's edges apply.
  always_comb begin
    hs_rise   = hsync_in & ~hs_prev_q;
    vs_rise   = vsync_in & ~vs_prev_q;
    locked    = (state_q == LOCKED) | vs_rise;
    state_d   = vs_rise ? LOCKED : state_q;
    hs_prev_d = hsync_in;
    vs_prev_d = vsync_in;

    line_eff = '0;
    hcnt_eff = '0;
    addr_eff = '0;
    if (locked) begin
      line_eff = vs_rise ? '0 : line_cnt_q;
      if (hs_rise && (line_eff != '1)) line_eff = line_eff + 1'b1;
      hcnt_eff = hs_rise ? '0 : hcnt_q;
      addr_eff = vs_rise ? '0 : addr_cnt_q;
    end

    line_cnt_d = line_eff;
    hcnt_d     = (!locked || (hcnt_eff == '1)) ? hcnt_eff : hcnt_eff + 1'b1;

    active = locked && (line_eff >= V_START) && (line_eff < V_END) &&
             (hcnt_eff >= H_START) && (hcnt_eff < H_END);

    addr_cnt_d = active ? addr_eff + 1'b1 : addr_eff;
    fb_rd_en_d = active;
    fb_addr_d  = active ? addr_eff : fb_addr_q;
    sync_err_d = (state_q == LOCKED) && vs_rise && (line_cnt_q != V_TOT);

    // Syncs, DE and frame marker ride one shift line so they land together with the read data.
    pipe_d[0] = '{hs: hsync_in, vs: vsync_in, de: active, fs: active && (addr_eff == '0)};
    for (int i = 1; i < L; i++) pipe_d[i] = pipe_q[i-1];

    vga_rgb_d = pipe_q[L-2].de ? fb_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UNLOCKED;
      hs_prev_q  <= 1'b1;
      vs_prev_q  <= 1'b1;
      hcnt_q     <= '0;
      line_cnt_q <= '0;
      addr_cnt_q <= '0;
      fb_rd_en_q <= 1'b0;
      fb_addr_q  <= '0;
      sync_err_q <= 1'b0;
      vga_rgb_q  <= '0;
      for (int i = 0; i < L; i++) pipe_q[i] <= TAP_RST;
    end else begin
      state_q    <= state_d;
      hs_prev_q  <= hs_prev_d;
      vs_prev_q  <= vs_prev_d;
      hcnt_q     <= hcnt_d;
      line_cnt_q <= line_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      fb_rd_en_q <= fb_rd_en_d;
      fb_addr_q  <= fb_addr_d;
      sync_err_q <= sync_err_d;
      vga_rgb_q  <= vga_rgb_d;
      pipe_q     <= pipe_d;
    end
  end

  assign fb_rd_en    = fb_rd_en_q;
  assign fb_addr     = fb_addr_q;
  assign sync_err    = sync_err_q;
  assign vga_rgb     = vga_rgb_q;
  assign vga_hsync   = pipe_q[L-1].hs;
  assign vga_vsync   = pipe_q[L-1].vs;
  assign vga_de      = pipe_q[L-1].de;
  assign frame_start = pipe_q[L-1].fs;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-size timing generator drives two instances (RD_LAT=2 and RD_LAT=1)
// and every output is compared each cycle against a model built from generator coordinates.
module tb_vga_scanout;

  localparam int H_ACTIVE    = 8;
  localparam int H_BACK      = 4;
  localparam int V_ACTIVE    = 3;
  localparam int V_BACK      = 2;
  localparam int V_TOTAL     = 7;
  localparam int PIX_W       = 12;
  localparam int ADDR_W      = 17;
  localparam int HP          = 16;
  localparam int HS_LOW      = 2;
  localparam int SHORT_FRAME = 3;
  localparam int MAXC        = 2048;

  logic clk = 1'b0;
  logic reset_n, hsync_in, vsync_in;

  logic              fb_rd_en_2, vga_hsync_2, vga_vsync_2, vga_de_2, frame_start_2, sync_err_2;
  logic [ADDR_W-1:0] fb_addr_2;
  logic [PIX_W-1:0]  fb_rdata_2, vga_rgb_2;
  logic              fb_rd_en_1, vga_hsync_1, vga_vsync_1, vga_de_1, frame_start_1, sync_err_1;
  logic [ADDR_W-1:0] fb_addr_1;
  logic [PIX_W-1:0]  fb_rdata_1, vga_rgb_1;

  logic [12:0] mem2_p0 = '0, mem2_p1 = '0, mem1_p0 = '0;

  always #5 clk = ~clk;

  vga_scanout #(.H_ACTIVE(H_ACTIVE), .H_BACK(H_BACK), .V_ACTIVE(V_ACTIVE), .V_BACK(V_BACK),
                .V_TOTAL(V_TOTAL), .RD_LAT(2), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_dut_lat2 (
    .clk(clk), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .fb_rd_en(fb_rd_en_2), .fb_addr(fb_addr_2), .fb_rdata(fb_rdata_2),
    .vga_hsync(vga_hsync_2), .vga_vsync(vga_vsync_2), .vga_rgb(vga_rgb_2), .vga_de(vga_de_2),
    .frame_start(frame_start_2), .sync_err(sync_err_2));

  vga_scanout #(.H_ACTIVE(H_ACTIVE), .H_BACK(H_BACK), .V_ACTIVE(V_ACTIVE), .V_BACK(V_BACK),
                .V_TOTAL(V_TOTAL), .RD_LAT(1), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_dut_lat1 (
    .clk(clk), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .fb_rd_en(fb_rd_en_1), .fb_addr(fb_addr_1), .fb_rdata(fb_rdata_1),
    .vga_hsync(vga_hsync_1), .vga_vsync(vga_vsync_1), .vga_rgb(vga_rgb_1), .vga_de(vga_de_1),
    .frame_start(frame_start_1), .sync_err(sync_err_1));

  // Memory models return addr[11:0] for an issued read and a marker value otherwise.
  always @(posedge clk) begin
    mem2_p0 <= {fb_rd_en_2, fb_addr_2[11:0]};
    mem2_p1 <= mem2_p0;
    mem1_p0 <= {fb_rd_en_1, fb_addr_1[11:0]};
  end
  assign fb_rdata_2 = mem2_p1[12] ? mem2_p1[11:0] : 12'hBAD;
  assign fb_rdata_1 = mem1_p0[12] ? mem1_p0[11:0] : 12'hBAD;

  logic h_hs [MAXC];
  logic h_vs [MAXC];
  logic h_de [MAXC];
  logic h_fs [MAXC];
  logic h_err [MAXC];
  int   h_addr [MAXC];

  int checks = 0, errors = 0;
  int cyc = 0, last_rst = 0, rise1_cyc = -1;
  int gh = HP - 1, gv = 1, frame = 0, nlines = V_TOTAL, prev_lines = V_TOTAL;
  bit locked = 1'b0, prev_vs = 1'b1, prev_rst = 1'b1;
  int first_de_2 = -1, first_de_1 = -1, de_cnt_f1 = 0, rd_cnt_f1 = 0;
  int err_cnt_2 = 0, err_cnt_1 = 0, fs_cnt_2 = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  // Advances the generator one clock, drives inputs, and records what the outputs must show later.
  task automatic applyStimulus;
    bit rst_low, hs, vs, rise, err, act;
    int addr;
    @(posedge clk);
    #1;
    cyc++;
    gh++;
    if (gh == HP) begin
      gh = 0;
      gv++;
      if (gv == nlines) begin
        gv = 0;
        frame++;
        prev_lines = nlines;
        nlines = (frame == SHORT_FRAME) ? V_TOTAL - 1 : V_TOTAL;
      end
    end
    rst_low  = (cyc <= 20) || (frame == 5 && gv == 2 && gh >= 6 && gh <= 8);
    hs       = (gh < HP - HS_LOW);
    vs       = (gv != nlines - 1);
    reset_n  = !rst_low;
    hsync_in = hs;
    vsync_in = vs;

    rise = !rst_low && !prev_rst && vs && !prev_vs;
    err  = 1'b0;
    if (rst_low) locked = 1'b0;
    if (rise) begin
      err    = locked && (prev_lines != V_TOTAL);
      locked = 1'b1;
      if (rise1_cyc < 0) rise1_cyc = cyc;
    end
    act  = locked && gv >= 1 && gv <= V_ACTIVE && gh >= H_BACK && gh < H_BACK + H_ACTIVE;
    addr = act ? (gv - 1) * H_ACTIVE + gh - H_BACK : 0;
    h_hs[cyc]   = hs;
    h_vs[cyc]   = vs;
    h_de[cyc]   = act;
    h_fs[cyc]   = act && (addr == 0);
    h_err[cyc]  = err;
    h_addr[cyc] = addr;
    if (rst_low) last_rst = cyc;
    prev_vs  = vs;
    prev_rst = rst_low;
  endtask

  task automatic check_dut(input string name, input int lat,
                           input logic hs, input logic vs, input logic de, input logic fs,
                           input logic err, input logic rd, input logic [ADDR_W-1:0] addr,
                           input logic [PIX_W-1:0] rgb);
    logic e_hs, e_vs, e_de, e_fs, e_rd, e_err;
    int   e_addr, a_rd;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_addr = 0;
    if (cyc - lat > last_rst) begin
      e_hs   = h_hs[cyc-lat];
      e_vs   = h_vs[cyc-lat];
      e_de   = h_de[cyc-lat];
      e_fs   = h_fs[cyc-lat];
      e_addr = h_addr[cyc-lat];
    end
    e_rd = 1'b0; e_err = 1'b0; a_rd = 0;
    if (cyc - 1 > last_rst) begin
      e_rd  = h_de[cyc-1];
      e_err = h_err[cyc-1];
      a_rd  = h_addr[cyc-1];
    end
    checkOutput({name, ".hsync"}, 32'(hs), 32'(e_hs));
    checkOutput({name, ".vsync"}, 32'(vs), 32'(e_vs));
    checkOutput({name, ".de"}, 32'(de), 32'(e_de));
    checkOutput({name, ".frame_start"}, 32'(fs), 32'(e_fs));
    checkOutput({name, ".rgb"}, 32'(rgb), e_de ? 32'(e_addr[11:0]) : 32'd0);
    checkOutput({name, ".rd_en"}, 32'(rd), 32'(e_rd));
    checkOutput({name, ".sync_err"}, 32'(err), 32'(e_err));
    if (e_rd) checkOutput({name, ".addr"}, 32'(addr), 32'(a_rd));
    else if (cyc == last_rst) checkOutput({name, ".addr_rst"}, 32'(addr), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    while (!(frame == 7 && gv == 0 && gh == 10) && cyc < MAXC - 2) begin
      applyStimulus();
      @(negedge clk);
      check_dut("lat2", 4, vga_hsync_2, vga_vsync_2, vga_de_2, frame_start_2, sync_err_2,
                fb_rd_en_2, fb_addr_2, vga_rgb_2);
      check_dut("lat1", 3, vga_hsync_1, vga_vsync_1, vga_de_1, frame_start_1, sync_err_1,
                fb_rd_en_1, fb_addr_1, vga_rgb_1);
      if (vga_de_2 && first_de_2 < 0) first_de_2 = cyc;
      if (vga_de_1 && first_de_1 < 0) first_de_1 = cyc;
      if (frame == 1) begin
        de_cnt_f1 += int'(vga_de_2);
        rd_cnt_f1 += int'(fb_rd_en_2);
      end
      err_cnt_2 += int'(sync_err_2);
      err_cnt_1 += int'(sync_err_1);
      fs_cnt_2  += int'(frame_start_2);
    end
    checkOutput("frame1_de_count", 32'(de_cnt_f1), 32'd24);
    checkOutput("frame1_read_count", 32'(rd_cnt_f1), 32'd24);
    checkOutput("first_de_delay_lat2", 32'(first_de_2 - rise1_cyc), 32'd24);
    checkOutput("first_de_delay_lat1", 32'(first_de_1 - rise1_cyc), 32'd23);
    checkOutput("sync_err_pulses_lat2", 32'(err_cnt_2), 32'd1);
    checkOutput("sync_err_pulses_lat1", 32'(err_cnt_1), 32'd1);
    checkOutput("frame_start_pulses", 32'(fs_cnt_2), 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
